// File: rtl/req_arbiter8_if.sv
// req_arbiter8_if: request/grant bundle between requesters and the arbiter.
//   en, mode, req                                 : requester side -> arbiter
//   grant, grant_idx, grant_valid, timeout_pulse  : arbiter -> requester side
interface req_arbiter8_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic             en;
    logic             mode;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout_pulse;

    modport master (
        output en, mode, req,
        input  grant, grant_idx, grant_valid, timeout_pulse
    );

    modport slave (
        input  en, mode, req,
        output grant, grant_idx, grant_valid, timeout_pulse
    );
endinterface

// File: rtl/req_arbiter8.sv
// req_arbiter8: holding arbiter, fixed highest-index or round-robin priority, optional hold limit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   arb   : slave side of req_arbiter8_if (en, mode, req in; grant, grant_idx, grant_valid, timeout_pulse out)
module req_arbiter8 #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    req_arbiter8_if.slave   arb
);
    // Counter must reach MAX_HOLD; with MAX_HOLD=0 it only saturates and is never compared.
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             tp_q, tp_d;
    logic [IDX_W-1:0] win_fp, win_rr, win;
    logic             limit_hit;

    // Fixed priority: last set bit seen while scanning upward is the highest index.
    always_comb begin
        win_fp = '0;
        for (int i = 0; i < N; i++)
            if (arb.req[i]) win_fp = IDX_W'(i);
    end

    // Round-robin: scan offsets downward so the smallest offset from rr_q wins.
    always_comb begin
        int j;
        win_rr = '0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(rr_q) + k) % N;
            if (arb.req[j]) win_rr = IDX_W'(j);
        end
    end

    assign win       = arb.mode ? win_rr : win_fp;
    assign limit_hit = (MAX_HOLD != 0) && (hold_q == HMAX);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        tp_d    = 1'b0;
        if (state_q == IDLE) begin
            if (arb.en && |arb.req) begin
                state_d = BUSY;
                grant_d = N'(1) << win;
                idx_d   = win;
                hold_d  = HW'(1);
                if (arb.mode) rr_d = (win == IDX_W'(N - 1)) ? '0 : win + 1'b1;
            end
        end else if (!arb.en || !arb.req[idx_q] || limit_hit) begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
            // Owner dropping req on the limit edge is a normal release, not a timeout.
            tp_d    = arb.en && arb.req[idx_q];
        end else begin
            hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            tp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            tp_q    <= tp_d;
        end
    end

    assign arb.grant         = grant_q;
    assign arb.grant_idx     = idx_q;
    assign arb.grant_valid   = (state_q == BUSY);
    assign arb.timeout_pulse = tp_q;
endmodule

// File: tb/tb_req_arbiter8.sv
// tb_req_arbiter8: table vectors, hand-written corner sequences and a random run against a reference model.
module tb_req_arbiter8;
    localparam int N  = 8;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    req_arbiter8_if #(.N(N), .IDX_W(3)) bus();

    req_arbiter8 #(.N(N), .IDX_W(3), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus.slave)
    );

    // Reference model: owner index or -1, round-robin start, grant-cycle count.
    int m_owner, m_last, m_rr, m_hold;
    bit m_tp;

    task automatic m_reset();
        m_owner = -1; m_last = 0; m_rr = 0; m_hold = 0; m_tp = 0;
    endtask

    task automatic m_edge();
        int w;
        m_tp = 0;
        if (m_owner < 0) begin
            if (bus.en && bus.req != 0) begin
                w = -1;
                if (bus.mode) begin
                    for (int k = 0; k < N && w < 0; k++)
                        if (bus.req[(m_rr + k) % N]) w = (m_rr + k) % N;
                    m_rr = (w + 1) % N;
                end else begin
                    for (int i = N - 1; i >= 0 && w < 0; i--)
                        if (bus.req[i]) w = i;
                end
                m_owner = w; m_last = w; m_hold = 1;
            end
        end else if (!bus.en || !bus.req[m_owner]) begin
            m_owner = -1; m_hold = 0;
        end else if (m_hold == MH) begin
            m_owner = -1; m_hold = 0; m_tp = 1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_grant"}, int'(bus.grant), (m_owner < 0) ? 0 : (1 << m_owner));
        chk({tag, "_idx"},   int'(bus.grant_idx), m_last);
        chk({tag, "_valid"}, int'(bus.grant_valid), int'(m_owner >= 0));
        chk({tag, "_tp"},    int'(bus.timeout_pulse), int'(m_tp));
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.mode = 1'b0; bus.req = '0;
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Structural invariants checked every cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            n_assert++;
            if ($countones(bus.grant) > 1 || bus.grant_valid !== (|bus.grant)) begin
                n_fail++;
                $display("FAIL onehot: grant=%b valid=%b", bus.grant, bus.grant_valid);
            end
        end
    end

    typedef struct {
        logic       en;
        logic       mode;
        logic [7:0] req;
        logic [7:0] grant;
        int         idx;
        logic       valid;
        logic       tp;
    } vec_t;

    vec_t vt[$];

    initial begin
        int pulses;
        // T2 fixed priority, then T5 enable behaviour.
        vt.push_back('{1'b1, 1'b0, 8'h26, 8'h20, 5, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h26, 8'h20, 5, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h06, 8'h00, 5, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h06, 8'h04, 2, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 2, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 8'hFF, 8'h00, 2, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 8'hFF, 8'h00, 2, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h08, 8'h08, 3, 1'b1, 1'b0});
        vt.push_back('{1'b0, 1'b0, 8'h08, 8'h00, 3, 1'b0, 1'b0});

        do_reset();
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_idx",   int'(bus.grant_idx), 0);
        chk("rst_valid", int'(bus.grant_valid), 0);
        chk("rst_tp",    int'(bus.timeout_pulse), 0);

        foreach (vt[i]) begin
            bus.en = vt[i].en; bus.mode = vt[i].mode; bus.req = vt[i].req;
            tick();
            chk($sformatf("vec%0d_grant", i), int'(bus.grant), int'(vt[i].grant));
            chk($sformatf("vec%0d_idx", i),   int'(bus.grant_idx), vt[i].idx);
            chk($sformatf("vec%0d_valid", i), int'(bus.grant_valid), int'(vt[i].valid));
            chk($sformatf("vec%0d_tp", i),    int'(bus.timeout_pulse), int'(vt[i].tp));
        end

        // T3 round-robin rotation: each owner holds two cycles, drops, re-asserts.
        do_reset();
        bus.en = 1'b1; bus.mode = 1'b1; bus.req = 8'hFF;
        for (int s = 0; s < 9; s++) begin
            tick();
            chk("t3_idx", int'(bus.grant_idx), s % 8);
            chk("t3_grant", int'(bus.grant), 1 << (s % 8));
            tick();
            bus.req = 8'hFF & ~(8'h01 << (s % 8));
            tick();
            chk("t3_release", int'(bus.grant_valid), 0);
            bus.req = 8'hFF;
        end

        // T4 hold limit in round-robin.
        do_reset();
        bus.en = 1'b1; bus.mode = 1'b1; bus.req = 8'h09;
        pulses = 0;
        for (int c = 0; c < MH; c++) begin
            tick();
            chk("t4_hold_idx", int'(bus.grant_idx), 0);
            chk("t4_hold_valid", int'(bus.grant_valid), 1);
            pulses += int'(bus.timeout_pulse);
        end
        tick();
        chk("t4_revoke_valid", int'(bus.grant_valid), 0);
        pulses += int'(bus.timeout_pulse);
        tick();
        chk("t4_next_idx", int'(bus.grant_idx), 3);
        pulses += int'(bus.timeout_pulse);
        chk("t4_pulse_count", pulses, 1);

        // T6 owner drops req on the edge the limit is reached.
        do_reset();
        bus.en = 1'b1; bus.mode = 1'b0; bus.req = 8'h01;
        for (int c = 0; c < MH; c++) tick();
        chk("t6_held", int'(bus.grant_valid), 1);
        bus.req = 8'h00;
        tick();
        chk("t6_valid", int'(bus.grant_valid), 0);
        chk("t6_tp", int'(bus.timeout_pulse), 0);

        // T1 asynchronous reset in the middle of a grant.
        bus.en = 1'b1; bus.mode = 1'b1; bus.req = 8'h40;
        tick();
        tick();
        chk("t1_pre_idx", int'(bus.grant_idx), 6);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("t1_grant", int'(bus.grant), 0);
        chk("t1_valid", int'(bus.grant_valid), 0);
        chk("t1_tp", int'(bus.timeout_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = 8'hFF;
        tick();
        chk("t1_rr_restart", int'(bus.grant_idx), 0);

        // Random run against the model.
        for (int c = 0; c < 600; c++) begin
            bus.en = ($urandom_range(7) != 0);
            if ($urandom_range(15) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(3) == 0) bus.req = 8'($urandom);
            tick();
            chk_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
